// File: rtl/soul_box_ctrl_if.sv
// Signal bundle between the input/tick side and the soul box controller.
// The master drives the buttons, tick and target strobe; the slave returns position, border and status.
interface soul_box_ctrl_if #(
    parameter int W = 10
);
    logic         tick;
    logic         btn_up;
    logic         btn_down;
    logic         btn_left;
    logic         btn_right;
    logic         load_target;
    logic [W-1:0] tgt_x1;
    logic [W-1:0] tgt_x2;
    logic [W-1:0] tgt_y1;
    logic [W-1:0] tgt_y2;
    logic [W-1:0] player_x;
    logic [W-1:0] player_y;
    logic [W-1:0] border_x1;
    logic [W-1:0] border_x2;
    logic [W-1:0] border_y1;
    logic [W-1:0] border_y2;
    logic         block_left;
    logic         block_right;
    logic         block_up;
    logic         block_down;
    logic         is_block;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output tick, btn_up, btn_down, btn_left, btn_right,
        output load_target, tgt_x1, tgt_x2, tgt_y1, tgt_y2,
        input  player_x, player_y, border_x1, border_x2, border_y1, border_y2,
        input  block_left, block_right, block_up, block_down, is_block,
        input  busy, done, err
    );

    modport slave (
        input  tick, btn_up, btn_down, btn_left, btn_right,
        input  load_target, tgt_x1, tgt_x2, tgt_y1, tgt_y2,
        output player_x, player_y, border_x1, border_x2, border_y1, border_y2,
        output block_left, block_right, block_up, block_down, is_block,
        output busy, done, err
    );
endinterface

// File: rtl/soul_box_ctrl.sv
// Registered soul position controller: per-tick movement clamped inside an animated border
// that slides toward a loaded target, with per-edge block flags.
module soul_box_ctrl #(
    parameter int W     = 10,
    parameter int R     = 8,
    parameter int STEP  = 2,
    parameter int BSTEP = 4,
    parameter int BX1   = 220,
    parameter int BX2   = 420,
    parameter int BY1   = 240,
    parameter int BY2   = 400
) (
    input logic          clk,
    input logic          reset,
    soul_box_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RESIZE, CLAMP} state_t;

    localparam logic [W-1:0] CX0 = W'((BX1 + BX2) / 2);
    localparam logic [W-1:0] CY0 = W'((BY1 + BY2) / 2);

    state_t       state, state_n;
    logic [W-1:0] bx1, bx2, by1, by2, bx1_n, bx2_n, by1_n, by2_n;
    logic [W-1:0] tx1, tx2, ty1, ty2, tx1_n, tx2_n, ty1_n, ty2_n;
    logic [W-1:0] nbx1, nbx2, nby1, nby2;
    logic [W-1:0] px, py, px_n, py_n;
    logic [3:0]   blk, blk_n;          // {left, right, up, down}
    logic         is_block, is_block_n, busy, busy_n, done, done_n, err, err_n;
    logic [W:0]   cand_x, cand_y;
    logic         bor_x, bor_y, at_tgt, tgt_ok;
    logic [W+1:0] cx, cy;

    // One edge moves toward its target by at most BSTEP.
    function automatic logic [W-1:0] step_edge(input logic [W-1:0] cur, input logic [W-1:0] tgt);
        logic [W-1:0] d;
        if (cur < tgt) begin
            d = tgt - cur;
            return (d > W'(BSTEP)) ? cur + W'(BSTEP) : tgt;
        end else begin
            d = cur - tgt;
            return (d > W'(BSTEP)) ? cur - W'(BSTEP) : tgt;
        end
    endfunction

    // Returns {low-edge hit, high-edge hit, clamped value}; borrow marks an underflowed candidate.
    function automatic logic [W+1:0] clamp_axis(input logic [W:0] cand, input logic borrow,
                                                input logic [W-1:0] e1, input logic [W-1:0] e2);
        logic [W:0] lo_lim, hi_lim;
        lo_lim = {1'b0, e1} + (W+1)'(R);
        hi_lim = {1'b0, e2} - (W+1)'(R);
        if (!borrow && (cand + (W+1)'(R) > {1'b0, e2}))
            return {2'b01, hi_lim[W-1:0]};
        else if (borrow || cand < lo_lim)
            return {2'b10, lo_lim[W-1:0]};
        else
            return {2'b00, cand[W-1:0]};
    endfunction

    always_comb begin
        state_n = state;
        bx1_n = bx1; bx2_n = bx2; by1_n = by1; by2_n = by2;
        tx1_n = tx1; tx2_n = tx2; ty1_n = ty1; ty2_n = ty2;
        px_n = px; py_n = py; blk_n = blk;
        done_n = 1'b0; err_n = 1'b0;
        nbx1 = bx1; nbx2 = bx2; nby1 = by1; nby2 = by2;
        cand_x = {1'b0, px}; bor_x = 1'b0;
        cand_y = {1'b0, py}; bor_y = 1'b0;

        if (bus.tick && state == RESIZE) begin
            nbx1 = step_edge(bx1, tx1);
            nbx2 = step_edge(bx2, tx2);
            nby1 = step_edge(by1, ty1);
            nby2 = step_edge(by2, ty2);
        end
        at_tgt = (nbx1 == tx1) && (nbx2 == tx2) && (nby1 == ty1) && (nby2 == ty2);

        if (bus.tick && bus.btn_right && !bus.btn_left) begin
            cand_x = {1'b0, px} + (W+1)'(STEP);
        end else if (bus.tick && bus.btn_left && !bus.btn_right) begin
            cand_x = {1'b0, px} - (W+1)'(STEP);
            bor_x  = (px < W'(STEP));
        end
        if (bus.tick && bus.btn_down && !bus.btn_up) begin
            cand_y = {1'b0, py} + (W+1)'(STEP);
        end else if (bus.tick && bus.btn_up && !bus.btn_down) begin
            cand_y = {1'b0, py} - (W+1)'(STEP);
            bor_y  = (py < W'(STEP));
        end

        // Clamp against the border this same tick produces, so the soul never leaves it.
        cx = clamp_axis(cand_x, bor_x, nbx1, nbx2);
        cy = clamp_axis(cand_y, bor_y, nby1, nby2);

        if (bus.tick) begin
            bx1_n = nbx1; bx2_n = nbx2; by1_n = nby1; by2_n = nby2;
            px_n  = cx[W-1:0];
            py_n  = cy[W-1:0];
            blk_n = {cx[W+1], cx[W], cy[W+1], cy[W]};
        end else if (state == CLAMP) begin
            px_n  = cx[W-1:0];
            py_n  = cy[W-1:0];
            blk_n = blk | {cx[W+1], cx[W], cy[W+1], cy[W]};
        end

        case (state)
            RESIZE:  if (bus.tick && at_tgt) state_n = CLAMP;
            CLAMP: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = state;
        endcase

        tgt_ok = (({1'b0, bus.tgt_x1} + (W+1)'(2 * R)) <= {1'b0, bus.tgt_x2}) &&
                 (({1'b0, bus.tgt_y1} + (W+1)'(2 * R)) <= {1'b0, bus.tgt_y2});
        if (bus.load_target) begin
            if (tgt_ok) begin
                tx1_n = bus.tgt_x1; tx2_n = bus.tgt_x2;
                ty1_n = bus.tgt_y1; ty2_n = bus.tgt_y2;
                state_n = RESIZE;
                done_n  = 1'b0;
            end else begin
                err_n = 1'b1;
            end
        end

        is_block_n = |blk_n;
        busy_n     = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            bx1 <= W'(BX1); bx2 <= W'(BX2); by1 <= W'(BY1); by2 <= W'(BY2);
            tx1 <= W'(BX1); tx2 <= W'(BX2); ty1 <= W'(BY1); ty2 <= W'(BY2);
            px <= CX0; py <= CY0;
            blk <= '0; is_block <= 1'b0; busy <= 1'b0; done <= 1'b0; err <= 1'b0;
        end else begin
            state <= state_n;
            bx1 <= bx1_n; bx2 <= bx2_n; by1 <= by1_n; by2 <= by2_n;
            tx1 <= tx1_n; tx2 <= tx2_n; ty1 <= ty1_n; ty2 <= ty2_n;
            px <= px_n; py <= py_n;
            blk <= blk_n; is_block <= is_block_n; busy <= busy_n; done <= done_n; err <= err_n;
        end
    end

    assign bus.player_x    = px;
    assign bus.player_y    = py;
    assign bus.border_x1   = bx1;
    assign bus.border_x2   = bx2;
    assign bus.border_y1   = by1;
    assign bus.border_y2   = by2;
    assign bus.block_left  = blk[3];
    assign bus.block_right = blk[2];
    assign bus.block_up    = blk[1];
    assign bus.block_down  = blk[0];
    assign bus.is_block    = is_block;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.err         = err;
endmodule

// File: tb/tb_soul_box_ctrl.sv
// Directed bench for soul_box_ctrl: a vector table for single-cycle behaviour plus
// hand-written sequences for wall clamping, border resize and reset mid-resize.
module tb_soul_box_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    soul_box_ctrl_if #(.W(10)) bus ();

    soul_box_ctrl #(
        .W(10), .R(8), .STEP(2), .BSTEP(4),
        .BX1(220), .BX2(420), .BY1(240), .BY2(400)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic [3:0] btn;       // {up, down, left, right}
        logic       load;
        logic [9:0] tx1, tx2, ty1, ty2;
        logic [9:0] px, py, bx1, bx2, by1, by2;
        logic [3:0] blk;       // {left, right, up, down}
        logic       busy, done, err;
    } vec_t;

    function automatic vec_t mk(logic tick, logic [3:0] btn, logic load,
                                int tx1, int tx2, int ty1, int ty2,
                                int px, int py, int bx1, int bx2, int by1, int by2,
                                logic [3:0] blk, logic busy, logic done, logic err);
        vec_t v;
        v.tick = tick; v.btn = btn; v.load = load;
        v.tx1 = 10'(tx1); v.tx2 = 10'(tx2); v.ty1 = 10'(ty1); v.ty2 = 10'(ty2);
        v.px = 10'(px); v.py = 10'(py);
        v.bx1 = 10'(bx1); v.bx2 = 10'(bx2); v.by1 = 10'(by1); v.by2 = 10'(by2);
        v.blk = blk; v.busy = busy; v.done = done; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int px, input int py,
                           input int bx1, input int bx2, input int by1, input int by2,
                           input logic [3:0] blk, input logic busy, input logic done, input logic err);
        chk({tag, " player_x"}, int'(bus.player_x), px);
        chk({tag, " player_y"}, int'(bus.player_y), py);
        chk({tag, " border_x1"}, int'(bus.border_x1), bx1);
        chk({tag, " border_x2"}, int'(bus.border_x2), bx2);
        chk({tag, " border_y1"}, int'(bus.border_y1), by1);
        chk({tag, " border_y2"}, int'(bus.border_y2), by2);
        chk({tag, " flags"}, int'({bus.block_left, bus.block_right, bus.block_up, bus.block_down}), int'(blk));
        chk({tag, " is_block"}, int'(bus.is_block), int'(|blk));
        chk({tag, " busy"}, int'(bus.busy), int'(busy));
        chk({tag, " done"}, int'(bus.done), int'(done));
        chk({tag, " err"}, int'(bus.err), int'(err));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic tick, input logic [3:0] btn, input logic load,
                          input int tx1, input int tx2, input int ty1, input int ty2);
        bus.tick = tick;
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = btn;
        bus.load_target = load;
        bus.tgt_x1 = 10'(tx1); bus.tgt_x2 = 10'(tx2);
        bus.tgt_y1 = 10'(ty1); bus.tgt_y2 = 10'(ty2);
    endtask

    task automatic do_reset();
        set_in(1'b0, 4'b0000, 1'b0, 0, 0, 0, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    vec_t vecs[11];

    initial begin
        logic done_seen;

        // Each row is one clk: inputs held for the cycle, expected outputs after its edge.
        vecs[0]  = mk(1, 4'b0001, 0,   0,   0,   0,   0, 322, 320, 220, 420, 240, 400, 4'b0000, 0, 0, 0);
        vecs[1]  = mk(1, 4'b0100, 0,   0,   0,   0,   0, 322, 322, 220, 420, 240, 400, 4'b0000, 0, 0, 0);
        vecs[2]  = mk(1, 4'b1011, 0,   0,   0,   0,   0, 322, 320, 220, 420, 240, 400, 4'b0000, 0, 0, 0);
        vecs[3]  = mk(0, 4'b0001, 0,   0,   0,   0,   0, 322, 320, 220, 420, 240, 400, 4'b0000, 0, 0, 0);
        vecs[4]  = mk(1, 4'b1000, 0,   0,   0,   0,   0, 322, 318, 220, 420, 240, 400, 4'b0000, 0, 0, 0);
        vecs[5]  = mk(0, 4'b0000, 1, 300, 310, 280, 360, 322, 318, 220, 420, 240, 400, 4'b0000, 0, 0, 1);
        vecs[6]  = mk(0, 4'b0000, 0,   0,   0,   0,   0, 322, 318, 220, 420, 240, 400, 4'b0000, 0, 0, 0);
        vecs[7]  = mk(0, 4'b0000, 1, 220, 420, 240, 396, 322, 318, 220, 420, 240, 400, 4'b0000, 1, 0, 0);
        vecs[8]  = mk(1, 4'b0000, 0,   0,   0,   0,   0, 322, 318, 220, 420, 240, 396, 4'b0000, 1, 0, 0);
        vecs[9]  = mk(0, 4'b0000, 0,   0,   0,   0,   0, 322, 318, 220, 420, 240, 396, 4'b0000, 0, 1, 0);
        vecs[10] = mk(0, 4'b0000, 0,   0,   0,   0,   0, 322, 318, 220, 420, 240, 396, 4'b0000, 0, 0, 0);

        set_in(1'b0, 4'b0000, 1'b0, 0, 0, 0, 0);
        reset = 1'b1;
        #12;
        chk_all("reset", 320, 320, 220, 420, 240, 400, 4'b0000, 0, 0, 0);
        reset = 1'b0;
        cyc();

        for (int i = 0; i < 11; i++) begin
            set_in(vecs[i].tick, vecs[i].btn, vecs[i].load, vecs[i].tx1, vecs[i].tx2, vecs[i].ty1, vecs[i].ty2);
            cyc();
            chk_all($sformatf("vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].bx1, vecs[i].bx2,
                    vecs[i].by1, vecs[i].by2, vecs[i].blk, vecs[i].busy, vecs[i].done, vecs[i].err);
        end

        // Right wall: 320 + 2n reaches 420-8 = 412 at tick 46, then holds with block_right.
        do_reset();
        for (int n = 1; n <= 50; n++) begin
            set_in(1'b1, 4'b0001, 1'b0, 0, 0, 0, 0);
            cyc();
            chk($sformatf("right t%0d player_x", n), int'(bus.player_x), (n <= 46) ? 320 + 2 * n : 412);
            chk($sformatf("right t%0d block_right", n), int'(bus.block_right), (n >= 47) ? 1 : 0);
        end
        chk("right is_block", int'(bus.is_block), 1);

        for (int n = 1; n <= 5; n++) begin
            set_in(1'b1, 4'b0011, 1'b0, 0, 0, 0, 0);
            cyc();
        end
        chk_all("both lr", 412, 320, 220, 420, 240, 400, 4'b0000, 0, 0, 0);

        // Shrinking right edge pushes the soul left by 4 per tick.
        set_in(1'b0, 4'b0000, 1'b1, 220, 400, 240, 400);
        cyc();
        chk("shrink load busy", int'(bus.busy), 1);
        for (int n = 1; n <= 5; n++) begin
            set_in(1'b1, 4'b0000, 1'b0, 0, 0, 0, 0);
            cyc();
            chk_all($sformatf("shrink t%0d", n), 412 - 4 * n, 320, 220, 420 - 4 * n, 240, 400, 4'b0100, 1, 0, 0);
        end
        set_in(1'b0, 4'b0000, 1'b0, 0, 0, 0, 0);
        cyc();
        chk("shrink done", int'(bus.done), 1);
        chk("shrink busy", int'(bus.busy), 0);
        chk("shrink player_x", int'(bus.player_x), 392);
        cyc();
        chk("shrink done drop", int'(bus.done), 0);

        // Left/up walls: y floor 248 reached at tick 36; x only reaches 240 in 40 ticks.
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            set_in(1'b1, 4'b1010, 1'b0, 0, 0, 0, 0);
            cyc();
            if (n == 36) chk_all("upleft t36", 248, 248, 220, 420, 240, 400, 4'b0000, 0, 0, 0);
        end
        chk_all("upleft t40", 240, 248, 220, 420, 240, 400, 4'b0010, 0, 0, 0);

        // Centred resize: y edges settle after 10 ticks, x edges after 20.
        do_reset();
        set_in(1'b0, 4'b0000, 1'b1, 300, 340, 280, 360);
        cyc();
        chk("resize busy", int'(bus.busy), 1);
        for (int n = 1; n <= 20; n++) begin
            set_in(1'b1, 4'b0000, 1'b0, 0, 0, 0, 0);
            cyc();
            if (n == 10) chk_all("resize t10", 320, 320, 260, 380, 280, 360, 4'b0000, 1, 0, 0);
        end
        chk_all("resize t20", 320, 320, 300, 340, 280, 360, 4'b0000, 1, 0, 0);
        set_in(1'b0, 4'b0000, 1'b0, 0, 0, 0, 0);
        cyc();
        chk_all("resize clamp", 320, 320, 300, 340, 280, 360, 4'b0000, 0, 1, 0);
        cyc();
        chk("resize done drop", int'(bus.done), 0);

        // Reset in the middle of a resize restores everything and suppresses done.
        do_reset();
        set_in(1'b0, 4'b0000, 1'b1, 300, 340, 280, 360);
        cyc();
        for (int n = 1; n <= 3; n++) begin
            set_in(1'b1, 4'b0000, 1'b0, 0, 0, 0, 0);
            cyc();
        end
        chk("midreset pre border_x1", int'(bus.border_x1), 232);
        #2;
        reset = 1'b1;
        #1;
        chk_all("midreset async", 320, 320, 220, 420, 240, 400, 4'b0000, 0, 0, 0);
        cyc();
        reset = 1'b0;
        chk_all("midreset held", 320, 320, 220, 420, 240, 400, 4'b0000, 0, 0, 0);
        done_seen = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            set_in(1'b1, 4'b0000, 1'b0, 0, 0, 0, 0);
            cyc();
            done_seen = done_seen | bus.done | bus.busy;
        end
        chk("midreset no done/busy", int'(done_seen), 0);
        chk_all("midreset after", 320, 320, 220, 420, 240, 400, 4'b0000, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
